cacheline_adaptor: RTL and testbench

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

---
 rtl/cacheline_adaptor.sv | 126 ++++++++++++
 tb/tb_cacheline_adaptor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor
//   Bridges a 256-bit cache-line interface (arbiter side) to a 4 x 64-bit
//   burst interface (physical memory side). One line request becomes four
//   acknowledged beats, followed by a single-cycle resp_o pulse.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : asynchronous reset, active low
//   line_i     : line to write (captured when a write is accepted)
//   line_o     : assembled read line, stable until the next read beat lands
//   address_i  : line address (captured when a request is accepted)
//   read_i     : line read request (wins over write_i)
//   write_i    : line write request
//   resp_o     : one-cycle completion pulse
//   burst_i    : read beat from memory
//   burst_o    : write beat to memory (0 outside WRITE)
//   address_o  : 32-byte aligned address while a burst is active, else 0
//   read_o     : burst read request
//   write_o    : burst write request
//   resp_i     : per-beat acknowledge from memory
// -----------------------------------------------------------------------------
module cacheline_adaptor (
   input  logic         clk,
   input  logic         rst,
   input  logic [255:0] line_i,
   output logic [255:0] line_o,
   input  logic [31:0]  address_i,
   input  logic         read_i,
   input  logic         write_i,
   output logic         resp_o,
   input  logic [63:0]  burst_i,
   output logic [63:0]  burst_o,
   output logic [31:0]  address_o,
   output logic         read_o,
   output logic         write_o,
   input  logic         resp_i
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t         r_state;
   state_t         w_next;
   logic [1:0]     r_cnt;
   logic [31:0]    r_addr;
   logic [255:0]   r_wline;
   logic [255:0]   r_rline;
   logic [7:0]     w_beat_lsb;

   // Bit offset of the current beat inside the line (cnt * 64).
   assign w_beat_lsb = {r_cnt, 6'd0};
   assign line_o     = r_rline;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   // Next state and outputs. Outputs are decoded from the state register so
   // that the asynchronous reset clears them in the same cycle.
   always_comb begin
      w_next    = r_state;
      read_o    = 1'b0;
      write_o   = 1'b0;
      resp_o    = 1'b0;
      address_o = 32'd0;
      burst_o   = 64'd0;
      case (r_state)
         IDLE: begin
            if (read_i)       w_next = READ;
            else if (write_i) w_next = WRITE;
         end
         READ: begin
            read_o    = 1'b1;
            address_o = {r_addr[31:5], 5'd0};
            if (resp_i && (r_cnt == 2'd3)) w_next = DONE;
         end
         WRITE: begin
            write_o   = 1'b1;
            address_o = {r_addr[31:5], 5'd0};
            burst_o   = r_wline[w_beat_lsb +: 64];
            if (resp_i && (r_cnt == 2'd3)) w_next = DONE;
         end
         DONE: begin
            resp_o = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Datapath: request capture in IDLE, beat counting and read assembly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= 2'd0;
         r_addr  <= 32'd0;
         r_wline <= 256'd0;
         r_rline <= 256'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (read_i) begin
                  r_addr <= address_i;
                  r_cnt  <= 2'd0;
               end else if (write_i) begin
                  r_addr  <= address_i;
                  r_wline <= line_i;
                  r_cnt   <= 2'd0;
               end
            end
            READ: begin
               if (resp_i) begin
                  r_rline[w_beat_lsb +: 64] <= burst_i;
                  r_cnt <= r_cnt + 2'd1;   // wraps to 0 on the last beat
               end
            end
            WRITE: begin
               if (resp_i) r_cnt <= r_cnt + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// tb_cacheline_adaptor
//   Scoreboarded bench: expected line_o values and write beats are queued when
//   a request is issued, and popped by a negedge monitor when the DUT emits
//   resp_o or a write beat is acknowledged. Inputs change #1 after posedge.
// -----------------------------------------------------------------------------
module tb_cacheline_adaptor;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] line_i, line_o;
   logic [31:0]  address_i, address_o;
   logic         read_i, write_i, resp_o;
   logic [63:0]  burst_i, burst_o;
   logic         read_o, write_o, resp_i;

   int n_tests = 0;
   int n_fail  = 0;
   int n_resp  = 0;

   logic [63:0]  q_beat[$];
   logic [255:0] q_line[$];
   logic [255:0] m_line = '0;   // expected line_o after the next resp_o

   cacheline_adaptor dut (
      .clk(clk), .rst(rst),
      .line_i(line_i), .line_o(line_o),
      .address_i(address_i), .read_i(read_i), .write_i(write_i),
      .resp_o(resp_o),
      .burst_i(burst_i), .burst_o(burst_o),
      .address_o(address_o), .read_o(read_o), .write_o(write_o),
      .resp_i(resp_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Monitor: completion lines and write beats against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         if (resp_o) begin
            n_resp++;
            if (q_line.size() == 0) chk("resp_unexp", resp_o, 1'b0);
            else                    chk("line_o", line_o, q_line.pop_front());
         end
         if (write_o) begin
            if (q_beat.size() == 0) chk("write_unexp", write_o, 1'b0);
            else begin
               chk("burst_o", burst_o, q_beat[0]);
               if (resp_i) void'(q_beat.pop_front());
            end
         end else begin
            chk("burst_o_zero", burst_o, 64'd0);
         end
      end
   end

   task automatic expect_xfer(input bit rd, input logic [255:0] l, input logic [63:0] d[4]);
      if (rd) m_line = {d[3], d[2], d[1], d[0]};
      else for (int i = 0; i < 4; i++) q_beat.push_back(l[64*i +: 64]);
      q_line.push_back(m_line);
   endtask

   // Called at posedge+#1 in IDLE; returns at posedge+#1 in the burst state.
   task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [255:0] l, input bit keep);
      read_i = rd; write_i = wr; address_i = a; line_i = l;
      @(posedge clk); #1;
      if (!keep) begin read_i = 1'b0; write_i = 1'b0; end
      chk("read_o", read_o, rd);
      chk("write_o", write_o, wr && !rd);
      chk("address_o", address_o, {a[31:5], 5'd0});
   endtask

   // Drives resp_i per pattern (1 once exhausted) until four beats are acked,
   // then checks the one-cycle DONE pulse.
   task automatic run_beats(input logic [63:0] d[4], input logic [7:0] pat, input int plen,
                            input bit perturb, input logic [31:0] exp_addr);
      int beat = 0;
      int k = 0;
      int r0 = n_resp;
      while (beat < 4 && k < 16) begin
         chk("addr_hold", address_o, exp_addr);
         resp_i  = (k < plen) ? pat[k] : 1'b1;
         burst_i = d[beat];
         if (perturb && k == 1) begin line_i = ~line_i; address_i = ~address_i; end
         @(posedge clk); #1;
         if (resp_i) beat++;
         k++;
      end
      resp_i = 1'b0; burst_i = '0;
      chk("beats_done", beat, 4);
      chk("resp_o", resp_o, 1'b1);
      chk("read_o_done", read_o, 1'b0);
      chk("write_o_done", write_o, 1'b0);
      chk("addr_done", address_o, 32'd0);
      @(posedge clk); #1;
      chk("resp_o_1cyc", resp_o, 1'b0);
      chk("resp_cnt", n_resp - r0, 1);
   endtask

   logic [63:0]  d1[4], d2[4], d3[4], d4[4], d5[4], dz[4];
   logic [255:0] wl;
   int           r_before;

   initial begin
      d1 = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
             64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
      d2 = '{64'hA0A0_0000_0000_0001, 64'hB1B1_0000_0000_0002,
             64'hC2C2_0000_0000_0003, 64'hD3D3_0000_0000_0004};
      d3 = '{64'hDEAD_BEEF_0000_0000, 64'h0000_0000_CAFE_F00D,
             64'h5555_AAAA_5555_AAAA, 64'hFFFF_0000_FFFF_0000};
      d4 = '{64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
             64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404};
      d5 = '{64'h9999_0000_0000_0001, 64'h8888_0000_0000_0002,
             64'h7777_0000_0000_0003, 64'h6666_0000_0000_0004};
      dz = '{64'd0, 64'd0, 64'd0, 64'd0};
      wl = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;

      rst = 1'b1; read_i = 0; write_i = 0; resp_i = 0;
      line_i = '0; address_i = '0; burst_i = '0;
      #1 rst = 1'b0;
      #1;
      chk("rst_read_o", read_o, 1'b0);
      chk("rst_write_o", write_o, 1'b0);
      chk("rst_resp_o", resp_o, 1'b0);
      chk("rst_address_o", address_o, 32'd0);
      chk("rst_burst_o", burst_o, 64'd0);
      chk("rst_line_o", line_o, 256'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Basic read, all beats back to back
      expect_xfer(1, '0, d1);
      issue(1, 0, 32'h0000_1234, '0, 0);
      chk("addr_1220", address_o, 32'h0000_1220);
      run_beats(d1, 8'hFF, 0, 0, 32'h0000_1220);
      chk("line_034", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

      // Stray resp_i in IDLE must not start anything
      resp_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("stray_read_o", read_o, 1'b0);
         chk("stray_write_o", write_o, 1'b0);
         chk("stray_resp_o", resp_o, 1'b0);
      end
      resp_i = 1'b0;

      // Gapped write with inputs changed mid-burst; line_o must not move
      expect_xfer(0, wl, dz);
      issue(0, 1, 32'hABCD_EF7F, wl, 0);
      run_beats(dz, 8'h59, 7, 1, 32'hABCD_EF60);

      // Read and write together: read wins
      expect_xfer(1, '0, d2);
      issue(1, 1, 32'h0000_0F00, ~wl, 0);
      run_beats(d2, 8'hFF, 0, 0, 32'h0000_0F00);

      // Reset after the second read beat
      r_before = n_resp;
      issue(1, 0, 32'h0000_0040, '0, 0);
      resp_i = 1'b1; burst_i = d3[0];
      @(posedge clk); #1;
      burst_i = d3[1];
      @(posedge clk); #1;
      resp_i = 1'b0;
      rst = 1'b0;
      #1;
      chk("mid_rst_read_o", read_o, 1'b0);
      chk("mid_rst_address_o", address_o, 32'd0);
      chk("mid_rst_line_o", line_o, 256'd0);
      chk("mid_rst_resp_o", resp_o, 1'b0);
      m_line = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_no_resp", n_resp - r_before, 0);
      expect_xfer(1, '0, d3);
      issue(1, 0, 32'h0000_0040, '0, 0);
      run_beats(d3, 8'h55, 8, 0, 32'h0000_0040);

      // Request held through DONE starts a second transaction
      expect_xfer(1, '0, d4);
      issue(1, 0, 32'h8000_003F, '0, 1);
      run_beats(d4, 8'hFF, 0, 0, 32'h8000_0020);
      expect_xfer(1, '0, d5);
      address_i = 32'h0000_2000;
      @(posedge clk); #1;
      read_i = 1'b0;
      chk("held_read_o", read_o, 1'b1);
      run_beats(d5, 8'hFF, 0, 0, 32'h0000_2000);

      repeat (2) @(posedge clk);
      #1;
      chk("sb_empty", q_line.size() + q_beat.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
